// File: rtl/regfile_pkg.sv
// Shared types and address helpers for the scoreboarded register file.
package regfile_pkg;

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = addr_width(NREGS_DEF);
    localparam int ZERO_REG  = 0;

    typedef logic [AW_DEF-1:0] reg_addr_t;

    typedef struct packed {
        logic                we;
        reg_addr_t           waddr;
        logic [XLEN_DEF-1:0] wdata;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_sel.sv
// Write-port match for one target address; the highest-index enabled port wins.
module regfile_wr_sel #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [AW-1:0]   addr,
    input  logic            we    [NWR],
    input  logic [AW-1:0]   waddr [NWR],
    input  logic [XLEN-1:0] wdata [NWR],
    output logic            hit,
    output logic [XLEN-1:0] data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan, so a later (younger) port overrides an earlier one.
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && (waddr[i] == addr)) begin
                hit  = 1'b1;
                data = wdata[i];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard and optional write bypass.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int NRSV   = 2,
    parameter int BYPASS = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [addr_width(NREGS)-1:0]  raddr     [NRD],
    output logic [XLEN-1:0]               rdata     [NRD],
    output logic                          rbusy     [NRD],
    input  logic                          we        [NWR],
    input  logic [addr_width(NREGS)-1:0]  waddr     [NWR],
    input  logic [XLEN-1:0]               wdata     [NWR],
    input  logic                          rsv_valid [NRSV],
    input  logic [addr_width(NREGS)-1:0]  rsv_addr  [NRSV],
    input  logic                          flush,
    output logic [$clog2(NREGS+1)-1:0]    busy_cnt
);

    localparam int AW = addr_width(NREGS);
    localparam int CW = $clog2(NREGS+1);

    logic [XLEN-1:0]  regs  [NREGS];
    logic [XLEN-1:0]  w_dat [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [NREGS-1:0] w_hit;
    logic [NREGS-1:0] rsv_hit;
    logic [CW-1:0]    cnt_nxt;

    for (genvar r = 0; r < NREGS; r++) begin : g_dec
        if (r == ZERO_REG) begin : g_zero
            assign w_hit[r] = 1'b0;
            assign w_dat[r] = '0;
        end else begin : g_reg
            regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_dec (
                .addr  (AW'(r)),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .hit   (w_hit[r]),
                .data  (w_dat[r])
            );
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic            b_hit;
        logic [XLEN-1:0] b_dat;
        logic            is_zero;
        logic            use_byp;

        regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
            .addr  (raddr[p]),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .hit   (b_hit),
            .data  (b_dat)
        );

        assign is_zero  = (int'(raddr[p]) == ZERO_REG);
        assign use_byp  = (BYPASS != 0) && b_hit;
        assign rdata[p] = is_zero ? '0 : (use_byp ? b_dat : regs[raddr[p]]);
        assign rbusy[p] = is_zero ? 1'b0 : (use_byp ? 1'b0 : busy[raddr[p]]);
    end

    // Flush beats a new claim, and a new claim beats a retiring write.
    always_comb begin
        rsv_hit  = '0;
        busy_nxt = '0;
        cnt_nxt  = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int k = 0; k < NRSV; k++) begin
                if (rsv_valid[k] && (int'(rsv_addr[k]) == r)) begin
                    rsv_hit[r] = 1'b1;
                end
            end
            if (r == ZERO_REG || flush) begin
                busy_nxt[r] = 1'b0;
            end else if (rsv_hit[r]) begin
                busy_nxt[r] = 1'b1;
            end else if (w_hit[r]) begin
                busy_nxt[r] = 1'b0;
            end else begin
                busy_nxt[r] = busy[r];
            end
            cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_hit[r]) begin
                    regs[r] <= w_dat[r];
                end
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb, with bypass and read-old-data instances.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int NRSV = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   raddr     [NRD];
    logic [XLEN-1:0] rdata_b   [NRD];
    logic [XLEN-1:0] rdata_n   [NRD];
    logic            rbusy_b   [NRD];
    logic            rbusy_n   [NRD];
    logic            we        [NWR];
    logic [AW-1:0]   waddr     [NWR];
    logic [XLEN-1:0] wdata     [NWR];
    logic            rsv_valid [NRSV];
    logic [AW-1:0]   rsv_addr  [NRSV];
    logic            flush;
    logic [CW-1:0]   cnt_b;
    logic [CW-1:0]   cnt_n;

    regfile_sb #(.BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(cnt_b)
    );

    regfile_sb #(.BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(cnt_n)
    );

    typedef struct packed {
        wr_req_t    w0;
        wr_req_t    w1;
        logic       rv0;
        reg_addr_t  ra0;
        logic       rv1;
        reg_addr_t  ra1;
        logic       fl;
        reg_addr_t  rd;
        logic [31:0] exp_d;
        logic       exp_b;
        logic [5:0] exp_cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t tab [NV];
    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < NWR; i++) begin
            we[i] = 1'b0; waddr[i] = '0; wdata[i] = '0;
        end
        for (int i = 0; i < NRSV; i++) begin
            rsv_valid[i] = 1'b0; rsv_addr[i] = '0;
        end
        flush = 1'b0;
    endtask

    task automatic rd_all(input logic [AW-1:0] a);
        for (int p = 0; p < NRD; p++) raddr[p] = a;
    endtask

    task automatic drive(input vec_t v);
        we[0] = v.w0.we; waddr[0] = v.w0.waddr; wdata[0] = v.w0.wdata;
        we[1] = v.w1.we; waddr[1] = v.w1.waddr; wdata[1] = v.w1.wdata;
        rsv_valid[0] = v.rv0; rsv_addr[0] = v.ra0;
        rsv_valid[1] = v.rv1; rsv_addr[1] = v.ra1;
        flush = v.fl;
        rd_all(v.rd);
    endtask

    localparam wr_req_t NOW = '{1'b0, 5'd0, 32'h0};

    initial begin
        //          w0                          w1                          rv0 ra0   rv1 ra1   fl  rd     exp_d         exp_b cnt
        tab[0]  = '{'{1'b1,5'd5,32'hDEAD}, NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd5,  32'hDEAD, 1'b0, 6'd0};
        tab[1]  = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd5,  32'hDEAD, 1'b0, 6'd0};
        tab[2]  = '{'{1'b1,5'd7,32'h11},   '{1'b1,5'd7,32'h22},        1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd7,  32'h22,   1'b0, 6'd0};
        tab[3]  = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd7,  32'h22,   1'b0, 6'd0};
        tab[4]  = '{NOW,                    NOW,                         1'b1,5'd3, 1'b0,5'd0, 1'b0,5'd3,  32'h0,    1'b0, 6'd1};
        tab[5]  = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd3,  32'h0,    1'b1, 6'd1};
        tab[6]  = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd3,  32'h0,    1'b1, 6'd1};
        tab[7]  = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd3,  32'h0,    1'b1, 6'd1};
        tab[8]  = '{'{1'b1,5'd3,32'h55},   NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd3,  32'h55,   1'b0, 6'd0};
        tab[9]  = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd3,  32'h55,   1'b0, 6'd0};
        tab[10] = '{NOW,                   '{1'b1,5'd9,32'h99},        1'b0,5'd0, 1'b1,5'd9, 1'b0,5'd9,  32'h99,   1'b0, 6'd1};
        tab[11] = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd9,  32'h99,   1'b1, 6'd1};
        tab[12] = '{NOW,                    NOW,                         1'b1,5'd1, 1'b1,5'd2, 1'b0,5'd9,  32'h99,   1'b1, 6'd3};
        tab[13] = '{NOW,                    NOW,                         1'b1,5'd4, 1'b0,5'd0, 1'b0,5'd1,  32'h0,    1'b1, 6'd4};
        tab[14] = '{NOW,                    NOW,                         1'b1,5'd6, 1'b0,5'd0, 1'b1,5'd6,  32'h0,    1'b0, 6'd0};
        tab[15] = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd6,  32'h0,    1'b0, 6'd0};
        tab[16] = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd9,  32'h99,   1'b0, 6'd0};
        tab[17] = '{'{1'b1,5'd0,32'hFFFF}, NOW,                         1'b1,5'd0, 1'b0,5'd0, 1'b0,5'd0,  32'h0,    1'b0, 6'd0};
        tab[18] = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0,  32'h0,    1'b0, 6'd0};
        tab[19] = '{'{1'b1,5'd10,32'hA},   '{1'b1,5'd11,32'hB},        1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd10, 32'hA,    1'b0, 6'd0};
        tab[20] = '{NOW,                    NOW,                         1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd11, 32'hB,    1'b0, 6'd0};

        idle();
        rd_all(5'd5);
        @(posedge clk); #1;
        chk("reset rdata", rdata_b[0], 32'h0);
        chk("reset rbusy", {31'h0, rbusy_b[0]}, 32'h0);
        chk("reset cnt", {26'h0, cnt_b}, 32'h0);
        chk("reset cnt nob", {26'h0, cnt_n}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tab[i]);
            #2;
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("vec%0d rdata%0d", i, p), rdata_b[p], tab[i].exp_d);
                chk($sformatf("vec%0d rbusy%0d", i, p), {31'h0, rbusy_b[p]}, {31'h0, tab[i].exp_b});
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d busy_cnt", i), {26'h0, cnt_b}, {26'h0, tab[i].exp_cnt});
        end

        // Mid-stream reset: state clears at once and the edge inside reset is lost.
        idle();
        rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd12;
        rd_all(5'd5);
        @(posedge clk); #1;
        chk("pre-reset cnt", {26'h0, cnt_b}, 32'd1);
        idle();
        rst_n = 1'b0;
        #2;
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("midrst rdata%0d", p), rdata_b[p], 32'h0);
            chk($sformatf("midrst rbusy%0d", p), {31'h0, rbusy_b[p]}, 32'h0);
        end
        chk("midrst cnt", {26'h0, cnt_b}, 32'h0);
        we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hBEEF;
        rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd12;
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        raddr[0] = 5'd5; raddr[1] = 5'd12; raddr[2] = 5'd7; raddr[3] = 5'd9;
        #2;
        chk("postrst x5", rdata_b[0], 32'h0);
        chk("postrst x12 busy", {31'h0, rbusy_b[1]}, 32'h0);
        chk("postrst x7", rdata_b[2], 32'h0);
        chk("postrst cnt", {26'h0, cnt_b}, 32'h0);
        @(posedge clk); #1;

        // Read-old-data instance: writes become visible one edge later.
        idle();
        we[1] = 1'b1; waddr[1] = 5'd13; wdata[1] = 32'h1234;
        rd_all(5'd13);
        #2;
        chk("nob same-cycle", rdata_n[0], 32'h0);
        chk("byp same-cycle", rdata_b[0], 32'h1234);
        @(posedge clk); #1;
        idle();
        #2;
        chk("nob next-cycle", rdata_n[0], 32'h1234);

        idle();
        we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'hFFFF;
        rsv_valid[1] = 1'b1; rsv_addr[1] = 5'd0;
        rd_all(5'd0);
        #2;
        chk("nob x0 rdata", rdata_n[0], 32'h0);
        chk("nob x0 rbusy", {31'h0, rbusy_n[0]}, 32'h0);
        @(posedge clk); #1;
        idle();
        #2;
        chk("nob x0 after", rdata_n[3], 32'h0);
        chk("nob x0 busy after", {31'h0, rbusy_n[3]}, 32'h0);
        chk("nob x0 cnt", {26'h0, cnt_n}, 32'h0);

        idle();
        we[0] = 1'b1; waddr[0] = 5'd14; wdata[0] = 32'h77;
        rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd14;
        rd_all(5'd14);
        #2;
        chk("nob rsv+wr old", rdata_n[1], 32'h0);
        chk("nob rsv+wr busy old", {31'h0, rbusy_n[1]}, 32'h0);
        @(posedge clk); #1;
        idle();
        #2;
        chk("nob rsv+wr data", rdata_n[1], 32'h77);
        chk("nob rsv+wr busy", {31'h0, rbusy_n[1]}, 32'h1);
        chk("nob rsv+wr cnt", {26'h0, cnt_n}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
